adma_tfr_sequencer: RTL and testbench

//  Executes the TRAN phase of one ADMA2 descriptor: walks DAT_ADR/DAT_LEN over the system-bus beat handshake.

---
 rtl/adma_tfr_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_adma_tfr_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adma_tfr_sequencer.sv
// adma_tfr_sequencer: TRAN-phase engine for one ADMA2 descriptor (bus beats, SD block gaps, TFC).
// Define ADMA_TFR_STALL_CNT_EN to build the bus stall-cycle counter; otherwise stall_cnt is tied to 0.
module adma_tfr_sequencer #(
  parameter int ADDR_W     = 64,
  parameter int LEN_W      = 16,
  parameter int BEAT_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_load,
  input  logic [11:0]       Block_Size,
  input  logic [15:0]       Block_Count,
  input  logic              Block_Count_Enable,
  input  logic              start,
  input  logic [ADDR_W-1:0] DAT_ADR,
  input  logic [LEN_W-1:0]  DAT_LEN,
  input  logic              dir,
  input  logic              Stop_At_Block_Gap,
  input  logic              Continue_Request,
  input  logic              abort,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  input  logic              bus_ready,
  output logic              TFC,
  output logic              blk_done,
  output logic              gap_stopped,
  output logic              Transfer_complete,
  output logic              enb_Transfer_complete,
  input  logic              ack_Transfer_complete,
  output logic              busy,
  output logic [31:0]       stall_cnt
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    XFER = 4'b0010,
    GAP  = 4'b0100,
    DONE = 4'b1000
  } state_e;

  localparam int REM_W = LEN_W + 1;
  localparam int BLK_W = 13;
  localparam logic [REM_W-1:0]  BEAT_REM = REM_W'(BEAT_BYTES);
  localparam logic [BLK_W-1:0]  BEAT_BLK = BLK_W'(BEAT_BYTES);
  localparam logic [ADDR_W-1:0] BEAT_ADR = ADDR_W'(BEAT_BYTES);
  localparam logic [REM_W-1:0]  FULL_LEN = {1'b1, {LEN_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_adr_q, cur_adr_d;
  logic [REM_W-1:0]  rem_len_q, rem_len_d;
  logic [BLK_W-1:0]  blk_bytes_q, blk_bytes_d;
  logic [15:0]       blk_left_q, blk_left_d;
  logic [11:0]       blk_size_q, blk_size_d;
  logic              cnt_en_q, cnt_en_d;
  logic              tfc_q, tfc_d;
  logic              blk_done_q, blk_done_d;

  logic              beat;
  logic              boundary;
  logic [BLK_W-1:0]  blk_bytes_inc;
  logic [REM_W-1:0]  rem_after;
  logic [15:0]       left_after;

  assign bus_valid             = (state_q == XFER);
  assign bus_addr              = bus_valid ? cur_adr_q : '0;
  assign bus_we                = bus_valid & dir;
  assign gap_stopped           = (state_q == GAP);
  assign Transfer_complete     = (state_q == DONE);
  assign enb_Transfer_complete = Transfer_complete;
  assign busy                  = (state_q != IDLE);
  assign TFC                   = tfc_q;
  assign blk_done              = blk_done_q;

  // Bytes beyond a non-multiple block size are dropped: the crossing beat closes the block.
  assign beat          = bus_valid & bus_ready;
  assign blk_bytes_inc = blk_bytes_q + BEAT_BLK;
  assign boundary      = (blk_size_q != 12'd0) && (blk_bytes_inc >= {1'b0, blk_size_q});
  assign rem_after     = (rem_len_q > BEAT_REM) ? (rem_len_q - BEAT_REM) : '0;
  assign left_after    = (boundary && cnt_en_q && (blk_left_q != 16'd0)) ?
                         (blk_left_q - 16'd1) : blk_left_q;

  always_comb begin
    state_d     = state_q;
    cur_adr_d   = cur_adr_q;
    rem_len_d   = rem_len_q;
    blk_bytes_d = blk_bytes_q;
    blk_left_d  = blk_left_q;
    blk_size_d  = blk_size_q;
    cnt_en_d    = cnt_en_q;
    tfc_d       = 1'b0;
    blk_done_d  = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_load) begin
            blk_size_d  = Block_Size;
            blk_left_d  = Block_Count;
            cnt_en_d    = Block_Count_Enable;
            blk_bytes_d = '0;
          end
          if (start) begin
            cur_adr_d = DAT_ADR;
            rem_len_d = (DAT_LEN == '0) ? FULL_LEN : {1'b0, DAT_LEN};
            state_d   = (cnt_en_q && (blk_left_q == 16'd0)) ? DONE : XFER;
          end
        end
        XFER: begin
          if (beat) begin
            cur_adr_d   = cur_adr_q + BEAT_ADR;
            rem_len_d   = rem_after;
            blk_bytes_d = boundary ? '0 : blk_bytes_inc;
            blk_left_d  = left_after;
            blk_done_d  = boundary;
            tfc_d       = (rem_after == '0);
            if (boundary && cnt_en_q && (left_after == 16'd0)) begin
              state_d = DONE;
            end else if (boundary && Stop_At_Block_Gap) begin
              state_d = GAP;
            end else if (rem_after == '0) begin
              state_d = IDLE;
            end
          end
        end
        GAP: begin
          if (Continue_Request) begin
            state_d = (rem_len_q != '0) ? XFER : IDLE;
          end
        end
        DONE: begin
          if (ack_Transfer_complete) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_adr_q   <= '0;
      rem_len_q   <= '0;
      blk_bytes_q <= '0;
      blk_left_q  <= '0;
      blk_size_q  <= '0;
      cnt_en_q    <= 1'b0;
      tfc_q       <= 1'b0;
      blk_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_adr_q   <= cur_adr_d;
      rem_len_q   <= rem_len_d;
      blk_bytes_q <= blk_bytes_d;
      blk_left_q  <= blk_left_d;
      blk_size_q  <= blk_size_d;
      cnt_en_q    <= cnt_en_d;
      tfc_q       <= tfc_d;
      blk_done_q  <= blk_done_d;
    end
  end

`ifdef ADMA_TFR_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cmd_load) begin
      stall_cnt_d = '0;
    end else if (bus_valid && !bus_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_adma_tfr_sequencer.sv
// tb_adma_tfr_sequencer: directed descriptor scenarios with random bus_ready, checked
// against a beat-level model of addresses, block boundaries and descriptor outcome.
`timescale 1ns/1ps
module tb_adma_tfr_sequencer;

  localparam int ADDR_W = 64;
  localparam int LEN_W  = 16;
  localparam int M_XFER = 0;
  localparam int M_IDLE = 1;
  localparam int M_GAP  = 2;
  localparam int M_DONE = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cmd_load;
  logic [11:0]       Block_Size;
  logic [15:0]       Block_Count;
  logic              Block_Count_Enable;
  logic              start;
  logic [ADDR_W-1:0] DAT_ADR;
  logic [LEN_W-1:0]  DAT_LEN;
  logic              dir;
  logic              Stop_At_Block_Gap;
  logic              Continue_Request;
  logic              abort;
  logic              bus_valid;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic              bus_ready;
  logic              TFC;
  logic              blk_done;
  logic              gap_stopped;
  logic              Transfer_complete;
  logic              enb_Transfer_complete;
  logic              ack_Transfer_complete;
  logic              busy;
  logic [31:0]       stall_cnt;

  always #5 clk = ~clk;

  adma_tfr_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .BEAT_BYTES(4)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .cmd_load              (cmd_load),
    .Block_Size            (Block_Size),
    .Block_Count           (Block_Count),
    .Block_Count_Enable    (Block_Count_Enable),
    .start                 (start),
    .DAT_ADR               (DAT_ADR),
    .DAT_LEN               (DAT_LEN),
    .dir                   (dir),
    .Stop_At_Block_Gap     (Stop_At_Block_Gap),
    .Continue_Request      (Continue_Request),
    .abort                 (abort),
    .bus_valid             (bus_valid),
    .bus_addr              (bus_addr),
    .bus_we                (bus_we),
    .bus_ready             (bus_ready),
    .TFC                   (TFC),
    .blk_done              (blk_done),
    .gap_stopped           (gap_stopped),
    .Transfer_complete     (Transfer_complete),
    .enb_Transfer_complete (enb_Transfer_complete),
    .ack_Transfer_complete (ack_Transfer_complete),
    .busy                  (busy),
    .stall_cnt             (stall_cnt)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] mAddr;
  int          mRem, mBlkBeat, mBps, mLeft, mNext;
  bit          mCntEn, mDir, expTfc, expBlk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit ld, input bit st, input bit cont, input bit ack, input bit ab);
    cmd_load              = ld;
    start                 = st;
    Continue_Request      = cont;
    ack_Transfer_complete = ack;
    abort                 = ab;
    tick();
    cmd_load              = 1'b0;
    start                 = 1'b0;
    Continue_Request      = 1'b0;
    ack_Transfer_complete = 1'b0;
    abort                 = 1'b0;
  endtask

  // A block of bs bytes closes on beat ceil(bs/4); bs=0 means no blocks at all.
  task automatic cmdLoad(input int bs, input int cnt, input bit en);
    Block_Size         = 12'(bs);
    Block_Count        = 16'(cnt);
    Block_Count_Enable = en;
    mBps     = (bs == 0) ? 0 : (bs + 3) / 4;
    mLeft    = cnt;
    mCntEn   = en;
    mBlkBeat = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic startDesc(input logic [63:0] adr, input int len, input bit d);
    DAT_ADR = adr;
    DAT_LEN = 16'(len);
    dir     = d;
    mAddr   = adr;
    mRem    = (len == 0) ? 65536 : len;
    mDir    = d;
    mNext   = (mCntEn && mLeft == 0) ? M_DONE : M_XFER;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic modelBeat(output bit ended);
    bit bnd;
    mAddr    = mAddr + 64'd4;
    mRem     = (mRem > 4) ? mRem - 4 : 0;
    bnd      = (mBps != 0) && (mBlkBeat + 1 == mBps);
    mBlkBeat = bnd ? 0 : mBlkBeat + 1;
    if (bnd && mCntEn) mLeft--;
    expBlk = bnd;
    expTfc = (mRem == 0);
    if (bnd && mCntEn && mLeft == 0) mNext = M_DONE;
    else if (bnd && Stop_At_Block_Gap) mNext = M_GAP;
    else if (mRem == 0) mNext = M_IDLE;
    else mNext = M_XFER;
    ended = (mNext != M_XFER);
  endtask

  task automatic checkEndState(input string tag);
    checkOutput({tag, "_busy"}, busy, 64'(mNext != M_IDLE));
    checkOutput({tag, "_gap"}, gap_stopped, 64'(mNext == M_GAP));
    checkOutput({tag, "_tc"}, Transfer_complete, 64'(mNext == M_DONE));
    checkOutput({tag, "_enb_tc"}, enb_Transfer_complete, 64'(mNext == M_DONE));
    checkOutput({tag, "_valid"}, bus_valid, 64'(mNext == M_XFER));
  endtask

  // Drives random bus_ready until the model says the descriptor leaves XFER.
  task automatic runBeats(input string tag, input int maxCycles, input int readyPct);
    int cyc;
    bit ended;
    cyc    = 0;
    ended  = 1'b0;
    expTfc = 1'b0;
    expBlk = 1'b0;
    while (!ended && cyc < maxCycles) begin
      bus_ready = ($urandom_range(99) < readyPct);
      checkOutput({tag, "_valid_mid"}, bus_valid, 64'd1);
      checkOutput({tag, "_blk_done"}, blk_done, 64'(expBlk));
      checkOutput({tag, "_tfc_mid"}, TFC, 64'd0);
      expBlk = 1'b0;
      if (bus_ready) begin
        checkOutput({tag, "_addr"}, bus_addr, mAddr);
        checkOutput({tag, "_we"}, bus_we, 64'(mDir));
        modelBeat(ended);
      end
      tick();
      cyc++;
    end
    bus_ready = 1'b0;
    checkOutput({tag, "_timeout"}, 64'(ended), 64'd1);
    checkOutput({tag, "_tfc_end"}, TFC, 64'(expTfc));
    checkOutput({tag, "_blk_done_end"}, blk_done, 64'(expBlk));
    checkEndState(tag);
  endtask

  initial begin
    int expStall;
    logic [63:0] radr;
    reset_n = 1'b0;
    cmd_load = 0; Block_Size = 0; Block_Count = 0; Block_Count_Enable = 0;
    start = 0; DAT_ADR = 0; DAT_LEN = 0; dir = 0; Stop_At_Block_Gap = 0;
    Continue_Request = 0; abort = 0; bus_ready = 0; ack_Transfer_complete = 0;
    repeat (3) tick();
    checkOutput("rst_valid", bus_valid, 64'd0);
    checkOutput("rst_addr", bus_addr, 64'd0);
    checkOutput("rst_busy", busy, 64'd0);
    checkOutput("rst_tfc", TFC, 64'd0);
    checkOutput("rst_tc", Transfer_complete, 64'd0);
    checkOutput("rst_stall", stall_cnt, 64'd0);
    reset_n = 1'b1;
    tick();

    $display("[TB] T1: two 512-byte blocks, counted");
    cmdLoad(512, 2, 1'b1);
    startDesc(64'h1000, 1024, 1'b1);
    runBeats("t1", 2000, 70);
    checkOutput("t1_final_addr", mAddr, 64'h1400);
    repeat (3) tick();
    checkOutput("t1_tc_held", Transfer_complete, 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_start_in_done", busy & Transfer_complete & !bus_valid, 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    mNext = M_IDLE;
    checkEndState("t1_ack");

    $display("[TB] T2: 6-byte descriptor");
    cmdLoad(0, 0, 1'b0);
    startDesc(64'h2000, 6, 1'b0);
    runBeats("t2", 100, 60);
    checkOutput("t2_final_addr", mAddr, 64'h2008);

    $display("[TB] T3: stop at block gap");
    cmdLoad(8, 0, 1'b0);
    Stop_At_Block_Gap = 1'b1;
    startDesc(64'h3000, 32, 1'b1);
    runBeats("t3a", 100, 60);
    for (int i = 0; i < 10; i++) begin
      checkOutput("t3_gap_hold", gap_stopped, 64'd1);
      checkOutput("t3_gap_novalid", bus_valid, 64'd0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      mNext = M_XFER;
      checkEndState("t3_resume");
      runBeats("t3b", 100, 60);
    end
    checkOutput("t3_tfc_seen_at_end", mRem, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    mNext = M_IDLE;
    checkEndState("t3_cont_empty");
    Stop_At_Block_Gap = 1'b0;

    $display("[TB] T4: stall on first beat");
    cmdLoad(0, 0, 1'b0);
    startDesc(64'h4000, 16, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus_ready = 1'b0;
      checkOutput("t4_addr_stable", bus_addr, 64'h4000);
      checkOutput("t4_valid_stable", bus_valid, 64'd1);
      tick();
    end
    runBeats("t4", 100, 100);
`ifdef ADMA_TFR_STALL_CNT_EN
    expStall = 5;
`else
    expStall = 0;
`endif
    checkOutput("t4_stall_cnt", stall_cnt, 64'(expStall));

    $display("[TB] T5: abort with same-cycle ready");
    cmdLoad(4, 1, 1'b1);
    startDesc(64'h5000, 4, 1'b0);
    bus_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    bus_ready = 1'b0;
    checkOutput("t5_valid", bus_valid, 64'd0);
    checkOutput("t5_busy", busy, 64'd0);
    checkOutput("t5_tfc", TFC, 64'd0);
    checkOutput("t5_blk_done", blk_done, 64'd0);
    checkOutput("t5_tc", Transfer_complete, 64'd0);
    tick();
    checkOutput("t5_tfc_later", TFC, 64'd0);
    startDesc(64'h5100, 4, 1'b0);
    runBeats("t5_redo", 100, 100);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t5_abort_done_tc", Transfer_complete, 64'd0);
    checkOutput("t5_abort_done_busy", busy, 64'd0);
    startDesc(64'h5200, 16, 1'b0);
    checkEndState("t5_zero_left");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t5_zero_left_ack", busy, 64'd0);

    $display("[TB] block carried across descriptors, non-multiple size");
    cmdLoad(10, 3, 1'b1);
    startDesc(64'h6000, 8, 1'b1);
    runBeats("cont_a", 100, 60);
    startDesc(64'h7000, 40, 1'b1);
    runBeats("cont_b", 200, 60);
    checkOutput("cont_left", mLeft, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] random descriptors");
    for (int r = 0; r < 4; r++) begin
      radr = {$urandom, $urandom} & ~64'd3;
      cmdLoad($urandom_range(0, 40), 0, 1'b0);
      startDesc(radr, $urandom_range(1, 120), 1'($urandom_range(0, 1)));
      runBeats("rand", 2000, 60);
    end

    $display("[TB] T6: 64 KiB descriptor with address wrap");
    cmdLoad(0, 0, 1'b0);
    startDesc(64'hFFFF_FFFF_FFFF_FFF0, 0, 1'b0);
    runBeats("t6", 40000, 85);
    checkOutput("t6_final_addr", mAddr, 64'h0000_0000_0000_FFF0);
    tick();
    checkOutput("t6_single_tfc", TFC, 64'd0);

    $display("[TB] reset mid-burst");
    startDesc(64'h8000, 64, 1'b0);
    bus_ready = 1'b1;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rstmid_valid", bus_valid, 64'd0);
    checkOutput("rstmid_busy", busy, 64'd0);
    checkOutput("rstmid_addr", bus_addr, 64'd0);
    checkOutput("rstmid_tfc", TFC, 64'd0);
    bus_ready = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
